// File: rtl/pb_debounce_pkg.sv
// Shared types and constants for the push-button debounce array.
// Optional auto-repeat is enabled by defining PB_REPEAT_EN.
package pb_debounce_pkg;

    localparam int unsigned DEF_NUM_CH          = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_ACTIVE_LOW      = 1;
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

    typedef enum logic [1:0] {
        StReleased,
        StChkPress,
        StPressed,
        StChkRelease
    } pb_state_e;

    // Width that holds the largest of the three terminal counts without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pb_debounce_if.sv
// Bundle of raw button inputs and debounced outputs for pb_debounce_array.
// pb_repeat only carries pulses when PB_REPEAT_EN is defined.
interface pb_debounce_if #(
    parameter int unsigned NUM_CH = pb_debounce_pkg::DEF_NUM_CH
);
    logic [NUM_CH-1:0] pb_raw;
    logic [NUM_CH-1:0] pb_level;
    logic [NUM_CH-1:0] pb_press;
    logic [NUM_CH-1:0] pb_release;
    logic [NUM_CH-1:0] pb_repeat;
    logic              any_event;

    modport master (
        output pb_raw,
        input  pb_level, pb_press, pb_release, pb_repeat, any_event
    );

    modport slave (
        input  pb_raw,
        output pb_level, pb_press, pb_release, pb_repeat, any_event
    );
endinterface

// File: rtl/pb_debounce_chan.sv
// One push-button channel: 2-flop synchroniser, debounce FSM and, when
// PB_REPEAT_EN is defined, a hold counter generating auto-repeat pulses.
module pb_debounce_chan
    import pb_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clkin_50,
    input  logic rst,
    input  logic pb_raw,
    output logic pb_level,
    output logic pb_press,
    output logic pb_release,
    output logic pb_repeat
);

    localparam int unsigned   CW           = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                                       REPEAT_PERIOD);
    localparam logic [CW-1:0] DB_LAST      = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RELEASED_RAW = (ACTIVE_LOW != 0);

    logic sync1_q, sync2_q, pressed;

    always_ff @(posedge clkin_50) begin
        if (rst) begin
            sync1_q <= RELEASED_RAW;
            sync2_q <= RELEASED_RAW;
        end else begin
            sync1_q <= pb_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ RELEASED_RAW;

    pb_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;

    always_ff @(posedge clkin_50) begin
        if (rst) begin
            state_q <= StReleased;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (pressed) begin
                    state_d = StChkPress;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StChkPress: begin
                if (!pressed) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                end
            end
            StPressed: begin
                if (!pressed) begin
                    state_d = StChkRelease;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            StChkRelease: begin
                if (pressed) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    assign pb_level   = level_q;
    assign pb_press   = press_q;
    assign pb_release = rel_q;

`ifdef PB_REPEAT_EN
    localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);

    logic [CW-1:0] hold_q, hold_d;
    logic          first_q, first_d;
    logic          rep_q, rep_d;

    always_ff @(posedge clkin_50) begin
        if (rst) begin
            hold_q  <= '0;
            first_q <= 1'b1;
            rep_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            first_q <= first_d;
            rep_q   <= rep_d;
        end
    end

    // Hold count only advances while stable in StPressed, so a release bounce freezes it.
    always_comb begin
        hold_d  = hold_q;
        first_d = first_q;
        rep_d   = 1'b0;
        if (state_q == StChkPress && state_d == StPressed) begin
            hold_d  = CW'(1);
            first_d = 1'b1;
        end else if (state_q == StPressed && pressed) begin
            if (hold_q == (first_q ? RPT_DELAY : RPT_PERIOD)) begin
                rep_d   = 1'b1;
                hold_d  = CW'(1);
                first_d = 1'b0;
            end else if (hold_q != '1) begin
                hold_d = hold_q + CW'(1);
            end
        end
    end

    assign pb_repeat = rep_q;
`else
    assign pb_repeat = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce_array.sv
// Array of NUM_CH independent debounced push-buttons plus a registered any_event flag.
// Define PB_REPEAT_EN to enable auto-repeat pulses on pb_repeat.
module pb_debounce_array
    import pb_debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEF_NUM_CH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned ACTIVE_LOW      = DEF_ACTIVE_LOW,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic          clkin_50,
    input  logic          rst,
    pb_debounce_if.slave  bus
);

    logic [NUM_CH-1:0] level, press, rel, rep, rep_evt;
    logic              any_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        pb_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clkin_50   (clkin_50),
            .rst        (rst),
            .pb_raw     (bus.pb_raw[i]),
            .pb_level   (level[i]),
            .pb_press   (press[i]),
            .pb_release (rel[i]),
            .pb_repeat  (rep[i])
        );
    end

`ifdef PB_REPEAT_EN
    assign rep_evt = rep;
`else
    assign rep_evt = '0;
`endif

    always_ff @(posedge clkin_50) begin
        if (rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |{press, rel, rep_evt};
        end
    end

    assign bus.pb_level   = level;
    assign bus.pb_press   = press;
    assign bus.pb_release = rel;
    assign bus.pb_repeat  = rep;
    assign bus.any_event  = any_q;

endmodule

// File: tb/tb_pb_debounce_array.sv
// Self-checking bench for pb_debounce_array: directed sequences, a vector table and
// random bouncing inputs against a run-length reference model (PB_REPEAT_EN aware).
module tb_pb_debounce_array;

    localparam int unsigned NCH = 4;
    localparam int unsigned DB  = 4;
    localparam int unsigned RD  = 10;
    localparam int unsigned RP  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pb_debounce_if #(.NUM_CH(NCH)) bus ();

    pb_debounce_array #(
        .NUM_CH          (NCH),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clkin_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: debounced level flips once the synced input has differed from it
    // for DB consecutive samples; repeats fire at hold ticks RD, RD+RP, RD+2RP, ...
    logic [NCH-1:0] m_s1, m_s2, m_level, m_press, m_rel, m_rep;
    logic           m_any;
    int             m_run   [NCH];
    int             m_ticks [NCH];

    int cyc_n;
    int n_press [NCH];
    int n_rel   [NCH];
    int n_rep   [NCH];
    int first_press [NCH];
    int first_any;
    int rep_at [$];

    typedef struct {
        logic [NCH-1:0] raw;
        int             n;
        logic [NCH-1:0] lvl;
        int             np;
        int             nr;
    } row_t;
    row_t rows [12];

    logic [NCH-1:0] rr;
    int             hold [NCH];
    int             sp, sr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic [NCH-1:0] raw, input logic r);
        logic [NCH-1:0] np, nr, nq;
        if (r) begin
            m_s1 = '1; m_s2 = '1; m_level = '0;
            m_press = '0; m_rel = '0; m_rep = '0; m_any = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_run[i] = 0;
                m_ticks[i] = 0;
            end
            return;
        end
        np = '0; nr = '0; nq = '0;
        m_any = |{m_press, m_rel, m_rep};
        for (int i = 0; i < NCH; i++) begin
            logic p;
            p = ~m_s2[i];
            if (p != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_level[i] = p;
                    m_run[i]   = 0;
                    if (p) begin
                        np[i] = 1'b1;
                        m_ticks[i] = 0;
                    end else begin
                        nr[i] = 1'b1;
                    end
                end
            end else begin
                if (p && m_run[i] == 0) begin
                    m_ticks[i]++;
`ifdef PB_REPEAT_EN
                    if (m_ticks[i] >= RD && (m_ticks[i] - RD) % RP == 0) nq[i] = 1'b1;
`endif
                end
                m_run[i] = 0;
            end
        end
        m_press = np; m_rel = nr; m_rep = nq;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic clr_obs();
        cyc_n = 0;
        first_any = -1;
        rep_at.delete();
        for (int i = 0; i < NCH; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_rep[i] = 0; first_press[i] = -1;
        end
    endtask

    task automatic cyc(input logic [NCH-1:0] raw, input logic r);
        bus.pb_raw = raw;
        rst = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
        cyc_n++;
        check("model", {bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_repeat, bus.any_event},
              {m_level, m_press, m_rel, m_rep, m_any});
        for (int i = 0; i < NCH; i++) begin
            if (bus.pb_press[i]) begin
                n_press[i]++;
                if (first_press[i] < 0) first_press[i] = cyc_n;
            end
            if (bus.pb_release[i]) n_rel[i]++;
            if (bus.pb_repeat[i]) begin
                n_rep[i]++;
                if (i == 0) rep_at.push_back(cyc_n);
            end
        end
        if (bus.any_event && first_any < 0) first_any = cyc_n;
    endtask

    initial begin
        rows[0]  = '{raw: 4'b1111, n: 8, lvl: 4'b0000, np: 0, nr: 0};
        rows[1]  = '{raw: 4'b1010, n: 8, lvl: 4'b0101, np: 2, nr: 0};
        rows[2]  = '{raw: 4'b1011, n: 3, lvl: 4'b0101, np: 0, nr: 0};
        rows[3]  = '{raw: 4'b1010, n: 8, lvl: 4'b0101, np: 0, nr: 0};
        rows[4]  = '{raw: 4'b1111, n: 8, lvl: 4'b0000, np: 0, nr: 2};
        rows[5]  = '{raw: 4'b0000, n: 8, lvl: 4'b1111, np: 4, nr: 0};
        rows[6]  = '{raw: 4'b1111, n: 5, lvl: 4'b1111, np: 0, nr: 0};
        rows[7]  = '{raw: 4'b1111, n: 1, lvl: 4'b0000, np: 0, nr: 4};
        rows[8]  = '{raw: 4'b0111, n: 4, lvl: 4'b0000, np: 0, nr: 0};
        rows[9]  = '{raw: 4'b1111, n: 8, lvl: 4'b0000, np: 1, nr: 1};
        rows[10] = '{raw: 4'b0111, n: 3, lvl: 4'b0000, np: 0, nr: 0};
        rows[11] = '{raw: 4'b1111, n: 8, lvl: 4'b0000, np: 0, nr: 0};

        clr_obs();
        repeat (3) cyc('1, 1'b1);
        check("reset_state", {bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_repeat,
                              bus.any_event}, '0);
        repeat (6) cyc('1, 1'b0);

        // Single press on channel 0: exact latency and one-cycle-later any_event.
        clr_obs();
        repeat (8) cyc(4'b1110, 1'b0);
        check("press0_latency", first_press[0], 6);
        check("press0_count", n_press[0], 1);
        check("any_after_press", first_any, 7);
        check("press0_level", {31'd0, bus.pb_level[0]}, 1);
        repeat (10) cyc('1, 1'b0);

        // Glitch of DB-1 clocks on channel 1.
        clr_obs();
        repeat (3) cyc(4'b1101, 1'b0);
        repeat (10) cyc('1, 1'b0);
        check("glitch1_press", n_press[1], 0);
        check("glitch1_release", n_rel[1], 0);
        check("glitch1_level", {31'd0, bus.pb_level[1]}, 0);

        // Channels 2 and 3 together.
        clr_obs();
        repeat (5) cyc(4'b0011, 1'b0);
        check("pair_early", bus.pb_press, 0);
        cyc(4'b0011, 1'b0);
        check("pair_press", bus.pb_press, 4'b1100);
        repeat (4) cyc(4'b0011, 1'b0);
        clr_obs();
        repeat (6) cyc('1, 1'b0);
        check("pair_release", bus.pb_release, 4'b1100);
        repeat (4) cyc('1, 1'b0);

        // Long hold on channel 0: auto-repeat schedule.
        clr_obs();
        repeat (36) cyc(4'b1110, 1'b0);
        check("hold_press", first_press[0], 6);
`ifdef PB_REPEAT_EN
        check("repeat_count", n_rep[0], 7);
        foreach (rep_at[k]) check("repeat_time", rep_at[k], 16 + 3 * k);
`else
        check("repeat_count", n_rep[0], 0);
`endif
        repeat (10) cyc('1, 1'b0);

        // Reset two clocks into the press check, button still held afterwards.
        clr_obs();
        repeat (4) cyc(4'b1110, 1'b0);
        cyc(4'b1110, 1'b1);
        check("rst_mid_press", n_press[0], 0);
        check("rst_outputs", {bus.pb_level, bus.pb_press, bus.pb_release, bus.pb_repeat,
                              bus.any_event}, '0);
        clr_obs();
        repeat (8) cyc(4'b1110, 1'b0);
        check("post_rst_press", first_press[0], 6);
        check("post_rst_count", n_press[0], 1);
        repeat (10) cyc('1, 1'b0);

        for (int r = 0; r < 12; r++) begin
            clr_obs();
            repeat (rows[r].n) cyc(rows[r].raw, 1'b0);
            sp = 0; sr = 0;
            for (int i = 0; i < NCH; i++) begin
                sp += n_press[i];
                sr += n_rel[i];
            end
            check("row_level", bus.pb_level, rows[r].lvl);
            check("row_press", sp, rows[r].np);
            check("row_release", sr, rows[r].nr);
        end

        // Random bouncing with occasional long holds and resets.
        rr = '1;
        for (int i = 0; i < NCH; i++) hold[i] = $urandom_range(1, 7);
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NCH; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    rr[i] = ~rr[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 40)
                                                          : $urandom_range(1, 7);
                end
            end
            cyc(rr, ($urandom_range(0, 199) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
